// File: rtl/keypad_scan_if.sv
// Keypad matrix and peripheral-side signals of the 4x4 keypad scanner.
// slave = scanner side, master = keypad/bus side.
interface keypad_scan_if;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] key_data;
  logic        key_clear;
  logic        key_irq;

  modport master (
    output row_in,
    output key_clear,
    input  col_out,
    input  key_data,
    input  key_irq
  );

  modport slave (
    input  row_in,
    input  key_clear,
    output col_out,
    output key_data,
    output key_irq
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: column scan, frame-level debounce, sticky press bitmap.
// Define KEYPAD_IRQ_EN to generate the one-cycle key_irq press pulse.
module keypad_scan #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  keypad_scan_if.slave  kp
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned STB_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_e;

  col_e             col_q, col_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q, prev_d;
  logic [15:0]      deb_q, deb_d;
  logic [15:0]      deb_dly_q;
  logic [15:0]      key_q, key_d;
  logic [STB_W-1:0] stb_q, stb_d;
  logic             sample;
  logic             frame_done;
  logic [15:0]      press_edge;

  always_comb begin
    sample     = (div_q == DIV_LAST);
    frame_done = sample && (col_q == COL3);
    div_d      = sample ? '0 : div_q + 1'b1;
    col_d      = col_q;
    raw_d      = raw_q;
    prev_d     = prev_q;
    deb_d      = deb_q;
    stb_d      = stb_q;

    if (sample) begin
      unique case (col_q)
        COL0:    col_d = COL1;
        COL1:    col_d = COL2;
        COL2:    col_d = COL3;
        default: col_d = COL0;
      endcase
      for (int unsigned r = 0; r < 4; r++) begin
        raw_d[{r[1:0], col_q}] = ~row_s2_q[r];
      end
    end

    // raw_d already holds column 3, so the compare sees the complete frame
    if (frame_done) begin
      if (raw_d == prev_q) begin
        stb_d = (stb_q == STB_MAX) ? stb_q : stb_q + 1'b1;
      end else begin
        stb_d = '0;
      end
      prev_d = raw_d;
      if (stb_d == STB_MAX) begin
        deb_d = raw_d;
      end
    end

    press_edge = deb_q & ~deb_dly_q;
    key_d      = (kp.key_clear ? '0 : key_q) | press_edge;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      col_q     <= COL0;
      div_q     <= '0;
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      raw_q     <= '0;
      prev_q    <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      stb_q     <= '0;
      key_q     <= '0;
    end else begin
      col_q     <= col_d;
      div_q     <= div_d;
      row_s1_q  <= kp.row_in;
      row_s2_q  <= row_s1_q;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      stb_q     <= stb_d;
      key_q     <= key_d;
    end
  end

  assign kp.col_out  = ~(4'b0001 << col_q);
  assign kp.key_data = key_q;

`ifdef KEYPAD_IRQ_EN
  logic irq_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |press_edge;
    end
  end

  assign kp.key_irq = irq_q;
`else
  assign kp.key_irq = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE_FRAMES=2, 16-cycle frames)
// with a scoreboard of expected key_data transitions.
module tb_keypad_scan;

  localparam int FRAME = 16;
`ifdef KEYPAD_IRQ_EN
  localparam int IRQ_PER = 1;
`else
  localparam int IRQ_PER = 0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] pressed;
  logic [15:0] last_kd;
  int          cyc;
  int          irq_cnt;
  int          passed;
  int          total;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  keypad_scan_if kp();

  keypad_scan #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .kp     (kp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low
  always_comb begin
    kp.row_in = '1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!kp.col_out[c] && pressed[r*4+c]) kp.row_in[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && kp.key_data !== last_kd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_key_data_change", kp.key_data, last_kd);
      end else begin
        check(tag_q.pop_front(), kp.key_data, exp_q.pop_front());
      end
    end
    last_kd <= kp.key_data;
    if (kp.key_irq === 1'b1) irq_cnt <= irq_cnt + 1;
  end

  task automatic push(input string tag, input logic [15:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    tag_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_start();
    do @(negedge clk); while (cyc % FRAME != 0);
  endtask

  task automatic pulse_clear(input string tag, input logic [15:0] val);
    kp.key_clear = 1'b1;
    push(tag, val);
    @(negedge clk);
    kp.key_clear = 1'b0;
    drain(tag, 4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] col_exp[5];
    int s;
    col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    passed = 0;
    total = 0;
    irq_cnt = 0;
    last_kd = '0;
    pressed = '0;
    kp.key_clear = 1'b0;
    rst = 1'b1;

    // 1. reset values and column stepping
    wait_cycles(3);
    check("reset_col_out", kp.col_out, 4'b1110);
    check("reset_key_data", kp.key_data, 16'h0000);
    check("reset_key_irq", kp.key_irq, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("col_step_%0d", i), kp.col_out, col_exp[i]);
      wait_cycles(4);
    end

    // 2. single held press of key 6 (row1/col2)
    wait_frame_start();
    pressed[6] = 1'b1;
    push("press_k6", 16'h0040);
    drain("press_k6", 4*FRAME + 4);
    wait_cycles(2*FRAME);
    check("irq_single_press", irq_cnt, IRQ_PER);

    // 4. clear while held, then release and re-press
    pulse_clear("clear_held", 16'h0000);
    wait_cycles(3*FRAME);
    check("held_no_reset", kp.key_data, 16'h0000);
    pressed[6] = 1'b0;
    wait_cycles(4*FRAME);
    wait_frame_start();
    pressed[6] = 1'b1;
    push("repress_k6", 16'h0040);
    drain("repress_k6", 4*FRAME + 4);
    pressed[6] = 1'b0;
    wait_cycles(4*FRAME);
    check("release_sticky", kp.key_data, 16'h0040);
    pulse_clear("clear_released", 16'h0000);

    // 3. one-frame glitch on key 0
    wait_frame_start();
    pressed[0] = 1'b1;
    wait_cycles(FRAME);
    pressed[0] = 1'b0;
    wait_cycles(6*FRAME);
    check("glitch_key_data", kp.key_data, 16'h0000);
    check("glitch_irq", irq_cnt, 2*IRQ_PER);

    // 5. key 15 press edge lands on the key_clear cycle
    wait_frame_start();
    pressed[0] = 1'b1;
    push("press_k0", 16'h0001);
    drain("press_k0", 4*FRAME + 4);
    wait_frame_start();
    s = cyc;
    pressed[15] = 1'b1;
    while (cyc != s + 3*FRAME) @(negedge clk);
    kp.key_clear = 1'b1;
    push("clear_vs_edge", 16'h8000);
    @(negedge clk);
    kp.key_clear = 1'b0;
    drain("clear_vs_edge", 4);
    wait_cycles(2*FRAME);
    check("edge_sticky", kp.key_data, 16'h8000);

    // 6. reset during column 2 with key 6 partially debounced
    pressed = '0;
    wait_cycles(4*FRAME);
    pulse_clear("clear_before_reset", 16'h0000);
    wait_cycles(2*FRAME);
    wait_frame_start();
    s = cyc;
    pressed[6] = 1'b1;
    while (cyc != s + 2*FRAME + 9) @(negedge clk);
    check("pre_reset_col2", kp.col_out, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_col_out", kp.col_out, 4'b1110);
    check("midreset_key_data", kp.key_data, 16'h0000);
    check("midreset_key_irq", kp.key_irq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push("reset_redebounce", 16'h0040);
    while (cyc != 3*FRAME) @(negedge clk);
    check("no_early_set", kp.key_data, 16'h0000);
    drain("reset_redebounce", 4);

    wait_cycles(2);
    check("irq_total", irq_cnt, 5*IRQ_PER);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
